ptc_rc_completer: RTL and testbench
===================================

Name: ptc_rc_completer

Overview:
- Completer model for the PTC read path.
- Accepts DMA read requests as they leave the PTC RQ side (header-only MVB-style: address, length, tag) and returns completions on a single-region RC MFB stream with the header on META.
- Splits each request on read-completion-boundary (RCB) boundaries and fills the payload with an address-derived pattern.
- Closes the RQ→RC loop in PTC benches and in loopback builds without a hard PCIe IP.

Parameters:
- MFB_DATA_WIDTH, 256, RC data width in bits; DW_PER_WORD = MFB_DATA_WIDTH/32 (power of 2, ≥2).
- ADDR_WIDTH, 64, request address width.
- LEN_WIDTH, 11, request length field in DW.
- TAG_WIDTH, 8, tag width.
- REQ_FIFO_DEPTH, 8, request buffer entries (power of 2).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous reset, active-high.
- RCB_SIZE  in  1  0 = 64 B RCB, 1 = 128 B RCB; sampled when a request is popped.
- RQ_ADDR  in  ADDR_WIDTH  byte address; bits [1:0] are ignored and treated as 0.
- RQ_LEN  in  LEN_WIDTH  length in DW; 0 is illegal.
- RQ_TAG  in  TAG_WIDTH  request tag.
- RQ_SRC_RDY  in  1  request valid.
- RQ_DST_RDY  out  1  request ready.
- RC_MFB_DATA  out  MFB_DATA_WIDTH  completion payload.
- RC_MFB_META  out  TAG_WIDTH+11+13+7  {LOWER_ADDR[6:0], BYTE_COUNT[12:0], CPL_LEN[10:0], TAG}, TAG in the LSBs.
- RC_MFB_SOF  out  1  first beat of a completion.
- RC_MFB_EOF  out  1  last beat of a completion.
- RC_MFB_EOF_POS  out  log2(DW_PER_WORD)  index of the last valid DW in the beat.
- RC_MFB_SRC_RDY  out  1  beat valid.
- RC_MFB_DST_RDY  in  1  sink ready.
- ERR_ZERO_LEN  out  1  one-cycle pulse when a request with length 0 is dropped.
- CNT_REQ  out  32  accepted legal requests (optional feature).
- CNT_CPL  out  32  completions sent (optional feature).

Behaviour:
- Reset (sync, takes effect the cycle after RESET is sampled high):
  - all outputs are 0, including RQ_DST_RDY, META and DATA;
  - request FIFO is emptied, FSM goes to IDLE, counters clear.
- Request side:
  - RQ_DST_RDY = !fifo_full && !RESET.
  - A request is accepted on RQ_SRC_RDY && RQ_DST_RDY.
  - A request with RQ_LEN = 0 is accepted but not stored; ERR_ZERO_LEN = 1 in the next cycle.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop one entry, latch addr/len/tag/RCB_SIZE, go to SEND.
  - SEND: drive completion beats.
    - Last beat of the last completion of a request, with DST_RDY: go to IDLE, or pop the next entry and stay in SEND (back-to-back, no bubble).
    - Last beat of a non-final completion, with DST_RDY: compute the next completion and stay in SEND.
- Latency: a request accepted in cycle N into an empty FIFO while IDLE gives its first beat with SRC_RDY = 1 in cycle N+2.
- Completion split, with rcb = 64 or 128 bytes and cur_addr / rem_dw as the running state:
  - CPL_LEN = min(rem_dw, (rcb − (cur_addr mod rcb))/4).
  - BYTE_COUNT = rem_dw*4 at the start of this completion, 13 bits; 4096 is representable.
  - LOWER_ADDR = cur_addr[6:0].
  - After each completion, cur_addr += CPL_LEN*4 and rem_dw −= CPL_LEN.
- Beats per completion: ceil(CPL_LEN/DW_PER_WORD).
  - SOF = 1 on the first beat, EOF = 1 on the last; a one-beat completion has both.
  - EOF_POS = (CPL_LEN−1) mod DW_PER_WORD; it is 0 when EOF = 0.
  - A beat never carries two packets.
- Payload: DW k of the request = lower 32 bits of (request_addr + 4k).
  - DW j of a beat sits at bits [32j+31:32j].
  - Unused DWs after EOF_POS are 0.
- META is valid on every beat of a completion and is constant across the beats of one completion.
- Backpressure: while SRC_RDY = 1 and DST_RDY = 0, DATA, META, SOF, EOF, EOF_POS and SRC_RDY hold their values.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, but RQ_DST_RDY is registered from the previous occupancy, so no overflow occurs. FIFO pointers wrap modulo REQ_FIFO_DEPTH.
- Reset mid-completion: SRC_RDY = 0 in the next cycle; the partial packet is abandoned and never resumed.

Optional Feature:
- Macro: PTC_RC_COMPLETER_CNT_EN.
- Defined:
  - CNT_REQ increments on each accepted legal request;
  - CNT_CPL increments on each EOF beat transferred (SRC_RDY && DST_RDY && EOF);
  - both counters are 32-bit, wrap at 2^32, and clear on reset.
- Not defined: CNT_REQ and CNT_CPL are tied to 0 and no counter logic is built.

Test Plan:
1. RCB_SIZE=0, addr 0x1000, len 16, tag 5, DST_RDY=1 → one completion: 2 beats, CPL_LEN=16, BYTE_COUNT=64, LOWER_ADDR=0x00, TAG=5, EOF_POS=7, DW0=0x1000, DW15=0x103C.
2. RCB_SIZE=0, addr 0x1038, len 8 → two completions:
   - first: CPL_LEN=2, BC=32, LA=0x38, 1 beat with SOF=EOF=1, EOF_POS=1;
   - second: CPL_LEN=6, BC=24, LA=0x40, EOF_POS=5.
3. RCB_SIZE=1, addr 0x2000, len 128 → 4 completions of 32 DW, 4 beats each; BC = 512, 384, 256, 128; no idle cycle between completions with DST_RDY=1.
4. DST_RDY held 0 for 5 cycles mid-packet and 9 requests pushed back-to-back → outputs stable while stalled; RQ_DST_RDY falls after 8 entries are stored; all 9 requests are completed in order with no loss.
5. Request with len 0, tag 3, followed by a legal request → ERR_ZERO_LEN pulses for 1 cycle; no completion carries tag 3; the legal request completes normally; CNT_REQ=1 when the macro is defined.
6. RESET asserted on the 2nd beat of a 4-beat completion → SRC_RDY=0 and RQ_DST_RDY=0 in the next cycle; after release, a new request produces SOF at N+2 with correct data.

Source files
------------

// File: rtl/ptc_rc_completer_if.sv
// ---------------------------------------------------------------------------
// ptc_rc_completer_if
//   Bundles the two streams of the PTC completer model.
//   RQ side (header-only requests): RQ_ADDR, RQ_LEN, RQ_TAG, RQ_SRC_RDY, RQ_DST_RDY.
//   RC side (single-region MFB completions, header on META):
//     RC_MFB_DATA, RC_MFB_META, RC_MFB_SOF, RC_MFB_EOF, RC_MFB_EOF_POS,
//     RC_MFB_SRC_RDY, RC_MFB_DST_RDY.
//   modport master: the requester / completion sink (drives RQ, accepts RC).
//   modport slave : the completer (accepts RQ, drives RC).
// ---------------------------------------------------------------------------
interface ptc_rc_completer_if #(
    parameter int unsigned MFB_DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned LEN_WIDTH      = 11,
    parameter int unsigned TAG_WIDTH      = 8
);
    localparam int unsigned EOF_POS_WIDTH = $clog2(MFB_DATA_WIDTH / 32);
    localparam int unsigned META_WIDTH    = TAG_WIDTH + 11 + 13 + 7;

    logic [ADDR_WIDTH-1:0]     RQ_ADDR;
    logic [LEN_WIDTH-1:0]      RQ_LEN;
    logic [TAG_WIDTH-1:0]      RQ_TAG;
    logic                      RQ_SRC_RDY;
    logic                      RQ_DST_RDY;

    logic [MFB_DATA_WIDTH-1:0] RC_MFB_DATA;
    logic [META_WIDTH-1:0]     RC_MFB_META;
    logic                      RC_MFB_SOF;
    logic                      RC_MFB_EOF;
    logic [EOF_POS_WIDTH-1:0]  RC_MFB_EOF_POS;
    logic                      RC_MFB_SRC_RDY;
    logic                      RC_MFB_DST_RDY;

    modport master (
        output RQ_ADDR, RQ_LEN, RQ_TAG, RQ_SRC_RDY,
        input  RQ_DST_RDY,
        input  RC_MFB_DATA, RC_MFB_META, RC_MFB_SOF, RC_MFB_EOF, RC_MFB_EOF_POS,
        input  RC_MFB_SRC_RDY,
        output RC_MFB_DST_RDY
    );

    modport slave (
        input  RQ_ADDR, RQ_LEN, RQ_TAG, RQ_SRC_RDY,
        output RQ_DST_RDY,
        output RC_MFB_DATA, RC_MFB_META, RC_MFB_SOF, RC_MFB_EOF, RC_MFB_EOF_POS,
        output RC_MFB_SRC_RDY,
        input  RC_MFB_DST_RDY
    );
endinterface

// File: rtl/ptc_rc_completer.sv
// ---------------------------------------------------------------------------
// ptc_rc_completer
//   Completer model closing the PTC RQ->RC loop. Buffers read requests, splits
//   each one on RCB boundaries and returns completions whose payload DW at
//   byte address A is A[31:0].
// Ports:
//   CLK, RESET     clock, synchronous active-high reset
//   RCB_SIZE       0 = 64 B, 1 = 128 B; sampled when a request is popped
//   bus_io         slave side of ptc_rc_completer_if (RQ requests, RC stream)
//   ERR_ZERO_LEN   one-cycle pulse after a zero-length request is dropped
//   CNT_REQ/CNT_CPL  accepted legal requests / completions sent
// Build option: define PTC_RC_COMPLETER_CNT_EN to build the counters;
//   otherwise CNT_REQ and CNT_CPL are tied to 0.
// ---------------------------------------------------------------------------
module ptc_rc_completer #(
    parameter int unsigned MFB_DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned LEN_WIDTH      = 11,
    parameter int unsigned TAG_WIDTH      = 8,
    parameter int unsigned REQ_FIFO_DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   RCB_SIZE,
    ptc_rc_completer_if.slave      bus_io,
    output logic                   ERR_ZERO_LEN,
    output logic [31:0]            CNT_REQ,
    output logic [31:0]            CNT_CPL
);
    localparam int unsigned DPW       = MFB_DATA_WIDTH / 32;
    localparam int unsigned DPW_LOG   = $clog2(DPW);
    localparam int unsigned PTR_W     = $clog2(REQ_FIFO_DEPTH);
    localparam int unsigned ENTRY_W   = ADDR_WIDTH + LEN_WIDTH + TAG_WIDTH;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    // ---------------- request FIFO ----------------
    logic [ENTRY_W-1:0]    mem_q [REQ_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q, count_d;
    logic                  rdy_q, err_q;
    logic                  accept, legal, push, pop, empty;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [LEN_WIDTH-1:0]  head_len;
    logic [TAG_WIDTH-1:0]  head_tag;

    assign bus_io.RQ_DST_RDY = rdy_q && !RESET;
    assign accept  = bus_io.RQ_SRC_RDY && bus_io.RQ_DST_RDY;
    assign legal   = bus_io.RQ_LEN != '0;
    assign push    = accept && legal;
    assign empty   = count_q == '0;
    assign count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    assign {head_addr, head_len, head_tag} = mem_q[rd_ptr_q];
    assign ERR_ZERO_LEN = err_q;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus_io.RQ_ADDR[ADDR_WIDTH-1:2], 2'b00, bus_io.RQ_LEN,
                                bus_io.RQ_TAG};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            // Ready follows the post-update occupancy, so a full FIFO is never pushed.
            rdy_q   <= count_d < (PTR_W+1)'(REQ_FIFO_DEPTH);
            err_q   <= accept && !legal;
        end
    end

    // ---------------- completion engine ----------------
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cpl_addr_q, cpl_addr_d;  // start address of current completion
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;            // DWs left at start of current completion
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;          // beat index within completion
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  rcb_q, rcb_d;

    logic [7:0]            rcb_bytes, room_bytes;
    logic [LEN_WIDTH-1:0]  room_dw, cpl_len, beat_base;
    logic [12:0]           byte_count;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [MFB_DATA_WIDTH-1:0] data;
    logic                  send, last_beat, final_cpl, fire;

    assign rcb_bytes  = rcb_q ? 8'd128 : 8'd64;
    assign room_bytes = rcb_bytes - ({1'b0, cpl_addr_q[6:0]} & (rcb_bytes - 8'd1));
    assign room_dw    = LEN_WIDTH'(room_bytes[7:2]);
    assign cpl_len    = (rem_q < room_dw) ? rem_q : room_dw;
    assign final_cpl  = cpl_len == rem_q;
    assign byte_count = 13'({rem_q, 2'b00});
    assign beat_base  = beat_q << DPW_LOG;
    assign last_beat  = (beat_base + LEN_WIDTH'(DPW)) >= cpl_len;
    assign beat_addr  = cpl_addr_q + ADDR_WIDTH'({beat_base, 2'b00});
    assign send       = state_q == StSend;
    assign fire       = send && bus_io.RC_MFB_DST_RDY;

    always_comb begin
        data = '0;
        for (int j = 0; j < DPW; j++) begin
            if (beat_base + LEN_WIDTH'(j) < cpl_len) begin
                data[32*j +: 32] = beat_addr[31:0] + 32'(4 * j);
            end
        end
    end

    assign bus_io.RC_MFB_SRC_RDY = send;
    assign bus_io.RC_MFB_DATA    = send ? data : '0;
    assign bus_io.RC_MFB_META    = send ? {cpl_addr_q[6:0], byte_count, 11'(cpl_len), tag_q} : '0;
    assign bus_io.RC_MFB_SOF     = send && (beat_q == '0);
    assign bus_io.RC_MFB_EOF     = send && last_beat;
    assign bus_io.RC_MFB_EOF_POS = (send && last_beat) ? $bits(bus_io.RC_MFB_EOF_POS)'(cpl_len - LEN_WIDTH'(1)) : '0;

    always_comb begin
        state_d    = state_q;
        cpl_addr_d = cpl_addr_q;
        rem_d      = rem_q;
        beat_d     = beat_q;
        tag_d      = tag_q;
        rcb_d      = rcb_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (fire) begin
                    if (!last_beat) begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end else if (!final_cpl) begin
                        cpl_addr_d = cpl_addr_q + ADDR_WIDTH'({cpl_len, 2'b00});
                        rem_d      = rem_q - cpl_len;
                        beat_d     = '0;
                    end else if (!empty) begin
                        pop = 1'b1;  // back-to-back request, no idle beat
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            cpl_addr_d = head_addr;
            rem_d      = head_len;
            tag_d      = head_tag;
            rcb_d      = RCB_SIZE;
            beat_d     = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            cpl_addr_q <= '0;
            rem_q      <= '0;
            beat_q     <= '0;
            tag_q      <= '0;
            rcb_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpl_addr_q <= cpl_addr_d;
            rem_q      <= rem_d;
            beat_q     <= beat_d;
            tag_q      <= tag_d;
            rcb_q      <= rcb_d;
        end
    end

`ifdef PTC_RC_COMPLETER_CNT_EN
    logic [31:0] cnt_req_q, cnt_cpl_q;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_req_q <= '0;
            cnt_cpl_q <= '0;
        end else begin
            if (push)              cnt_req_q <= cnt_req_q + 32'd1;
            if (fire && last_beat) cnt_cpl_q <= cnt_cpl_q + 32'd1;
        end
    end
    assign CNT_REQ = cnt_req_q;
    assign CNT_CPL = cnt_cpl_q;
`else
    assign CNT_REQ = '0;
    assign CNT_CPL = '0;
`endif
endmodule

// File: tb/tb_ptc_rc_completer.sv
// ---------------------------------------------------------------------------
// tb_ptc_rc_completer
//   Directed bench for ptc_rc_completer. Inputs change 1 time unit after the
//   rising edge; outputs are sampled on the falling edge. A monitor records
//   every transferred RC beat with its cycle number.
// ---------------------------------------------------------------------------
module tb_ptc_rc_completer;
    logic        clk;
    logic        rst;
    logic        rcb;
    logic        err;
    logic [31:0] cnt_req, cnt_cpl;
    int          cyc;
    int          checks;
    int          fails;
    int          acc_cyc;

    logic [255:0] q_data[$];
    logic [38:0]  q_meta[$];
    logic         q_sof[$];
    logic         q_eof[$];
    logic [2:0]   q_pos[$];
    int           q_cyc[$];

    ptc_rc_completer_if bus ();

    ptc_rc_completer u_dut (
        .CLK          (clk),
        .RESET        (rst),
        .RCB_SIZE     (rcb),
        .bus_io       (bus),
        .ERR_ZERO_LEN (err),
        .CNT_REQ      (cnt_req),
        .CNT_CPL      (cnt_cpl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.RC_MFB_SRC_RDY && bus.RC_MFB_DST_RDY) begin
            q_data.push_back(bus.RC_MFB_DATA);
            q_meta.push_back(bus.RC_MFB_META);
            q_sof.push_back(bus.RC_MFB_SOF);
            q_eof.push_back(bus.RC_MFB_EOF);
            q_pos.push_back(bus.RC_MFB_EOF_POS);
            q_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] dw(input logic [255:0] d, input int j);
        return d[32*j +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete(); q_meta.delete(); q_sof.delete();
        q_eof.delete();  q_pos.delete();  q_cyc.delete();
    endtask

    task automatic push_req(input logic [63:0] addr, input logic [10:0] len,
                            input logic [7:0] tag);
        bit acc;
        acc = 1'b0;
        bus.RQ_ADDR = addr;
        bus.RQ_LEN = len;
        bus.RQ_TAG = tag;
        bus.RQ_SRC_RDY = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (bus.RQ_DST_RDY === 1'b1) begin
                acc = 1'b1;
                acc_cyc = cyc;
            end
            tick();
        end
        bus.RQ_SRC_RDY = 1'b0;
        checks++;
        if (!acc) begin
            fails++;
            $display("FAIL req_accept tag=%0h: accepted=%0d required=1", tag, acc);
        end
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (q_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL beat_wait: got=%0d beats required=%0d", q_data.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({bus.RC_MFB_SRC_RDY, bus.RQ_DST_RDY, err, bus.RC_MFB_SOF, bus.RC_MFB_EOF} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got=%b required=00000",
                     {bus.RC_MFB_SRC_RDY, bus.RQ_DST_RDY, err, bus.RC_MFB_SOF, bus.RC_MFB_EOF});
        end
        checks++;
        if (bus.RC_MFB_DATA !== '0 || bus.RC_MFB_META !== '0 || cnt_req !== 0 || cnt_cpl !== 0) begin
            fails++;
            $display("FAIL reset_bus: data=%h meta=%h cnt=%0d/%0d required all zero",
                     bus.RC_MFB_DATA, bus.RC_MFB_META, cnt_req, cnt_cpl);
        end
        tick();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.RQ_DST_RDY !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got=%b required=1", bus.RQ_DST_RDY);
        end
        tick();
    endtask

    task automatic test_single();
        bit ok;
        rcb = 1'b0;
        bus.RC_MFB_DST_RDY = 1'b1;
        clear_q();
        push_req(64'h1000, 11'd16, 8'd5);
        @(negedge clk);
        checks++;
        if (bus.RC_MFB_SRC_RDY !== 1'b0) begin
            fails++;
            $display("FAIL single_early: src_rdy=%b required=0 at N+1", bus.RC_MFB_SRC_RDY);
        end
        wait_beats(2, ok);
        if (ok) begin
            checks++;
            if (q_cyc[0] !== acc_cyc + 2) begin
                fails++;
                $display("FAIL single_latency: cycle=%0d required=%0d", q_cyc[0], acc_cyc + 2);
            end
            checks++;
            if (q_meta[0] !== {7'h00, 13'd64, 11'd16, 8'd5} || q_meta[1] !== q_meta[0]) begin
                fails++;
                $display("FAIL single_meta: got=%h/%h required=%h", q_meta[0], q_meta[1],
                         {7'h00, 13'd64, 11'd16, 8'd5});
            end
            checks++;
            if ({q_sof[0], q_eof[0], q_pos[0], q_sof[1], q_eof[1], q_pos[1]} !== 10'b10_000_01_111) begin
                fails++;
                $display("FAIL single_framing: got=%b required=1000001111",
                         {q_sof[0], q_eof[0], q_pos[0], q_sof[1], q_eof[1], q_pos[1]});
            end
            checks++;
            if (dw(q_data[0], 0) !== 32'h1000 || dw(q_data[1], 7) !== 32'h103C) begin
                fails++;
                $display("FAIL single_data: dw0=%h dw15=%h required=1000/103c",
                         dw(q_data[0], 0), dw(q_data[1], 7));
            end
        end
        tick();
    endtask

    task automatic test_rcb_split();
        bit ok;
        rcb = 1'b0;
        clear_q();
        push_req(64'h1038, 11'd8, 8'd7);
        wait_beats(2, ok);
        if (ok) begin
            checks++;
            if (q_meta[0] !== {7'h38, 13'd32, 11'd2, 8'd7} || q_sof[0] !== 1'b1 ||
                q_eof[0] !== 1'b1 || q_pos[0] !== 3'd1) begin
                fails++;
                $display("FAIL split_first: meta=%h sof=%b eof=%b pos=%0d required=%h 1 1 1",
                         q_meta[0], q_sof[0], q_eof[0], q_pos[0], {7'h38, 13'd32, 11'd2, 8'd7});
            end
            checks++;
            if (q_meta[1] !== {7'h40, 13'd24, 11'd6, 8'd7} || q_pos[1] !== 3'd5 ||
                q_sof[1] !== 1'b1 || q_eof[1] !== 1'b1) begin
                fails++;
                $display("FAIL split_second: meta=%h pos=%0d required=%h pos 5",
                         q_meta[1], q_pos[1], {7'h40, 13'd24, 11'd6, 8'd7});
            end
            checks++;
            if (dw(q_data[0], 1) !== 32'h103C || dw(q_data[0], 2) !== 32'h0 ||
                dw(q_data[1], 5) !== 32'h1054 || dw(q_data[1], 6) !== 32'h0) begin
                fails++;
                $display("FAIL split_data: %h %h %h %h required=103c 0 1054 0",
                         dw(q_data[0], 1), dw(q_data[0], 2), dw(q_data[1], 5), dw(q_data[1], 6));
            end
            checks++;
            if (q_cyc[1] !== q_cyc[0] + 1) begin
                fails++;
                $display("FAIL split_gap: second at %0d required=%0d", q_cyc[1], q_cyc[0] + 1);
            end
        end
        tick();
    endtask

    task automatic test_rcb128();
        bit ok;
        int bc_tab[4] = '{512, 384, 256, 128};
        rcb = 1'b1;
        clear_q();
        push_req(64'h2000, 11'd128, 8'h09);
        wait_beats(16, ok);
        if (ok) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if ({q_sof[4*c], q_meta[4*c]} !== {1'b1, 7'h00, 13'(bc_tab[c]), 11'd32, 8'h09}) begin
                    fails++;
                    $display("FAIL rcb128_head[%0d]: sof=%b meta=%h required=1 %h", c, q_sof[4*c],
                             q_meta[4*c], {7'h00, 13'(bc_tab[c]), 11'd32, 8'h09});
                end
                checks++;
                if ({q_eof[4*c+3], q_pos[4*c+3], q_eof[4*c+2]} !== 5'b1_111_0) begin
                    fails++;
                    $display("FAIL rcb128_tail[%0d]: got=%b required=11110", c,
                             {q_eof[4*c+3], q_pos[4*c+3], q_eof[4*c+2]});
                end
            end
            checks++;
            if (q_cyc[15] !== q_cyc[0] + 15) begin
                fails++;
                $display("FAIL rcb128_bubble: span=%0d required=15", q_cyc[15] - q_cyc[0]);
            end
            checks++;
            if (dw(q_data[15], 7) !== 32'h21FC || dw(q_data[4], 0) !== 32'h2080) begin
                fails++;
                $display("FAIL rcb128_data: %h %h required=21fc 2080",
                         dw(q_data[15], 7), dw(q_data[4], 0));
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit hold_ok;
        logic [255:0] s_data;
        logic [38:0]  s_meta;
        logic [5:0]   s_flags;
        rcb = 1'b0;
        bus.RC_MFB_DST_RDY = 1'b0;
        clear_q();
        for (int i = 0; i < 9; i++) push_req(64'h3000 + 64'(256 * i), 11'd16, 8'(16 + i));
        @(negedge clk);
        checks++;
        if (bus.RQ_DST_RDY !== 1'b0) begin
            fails++;
            $display("FAIL fifo_full_ready: got=%b required=0", bus.RQ_DST_RDY);
        end
        tick();
        bus.RC_MFB_DST_RDY = 1'b1;
        tick();
        bus.RC_MFB_DST_RDY = 1'b0;
        @(negedge clk);
        s_data = bus.RC_MFB_DATA;
        s_meta = bus.RC_MFB_META;
        s_flags = {bus.RC_MFB_SRC_RDY, bus.RC_MFB_SOF, bus.RC_MFB_EOF, bus.RC_MFB_EOF_POS};
        hold_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.RC_MFB_DATA !== s_data || bus.RC_MFB_META !== s_meta ||
                {bus.RC_MFB_SRC_RDY, bus.RC_MFB_SOF, bus.RC_MFB_EOF, bus.RC_MFB_EOF_POS} !== s_flags)
                hold_ok = 1'b0;
        end
        checks++;
        if (!hold_ok) begin
            fails++;
            $display("FAIL stall_hold: outputs=%b changed during stall required=1", hold_ok);
        end
        checks++;
        if (s_flags !== 6'b1_0_1_111 || dw(s_data, 7) !== 32'h303C || s_meta[7:0] !== 8'h10) begin
            fails++;
            $display("FAIL stall_beat: flags=%b dw7=%h tag=%h required=101111 303c 10",
                     s_flags, dw(s_data, 7), s_meta[7:0]);
        end
        tick();
        bus.RC_MFB_DST_RDY = 1'b1;
        wait_beats(18, ok);
        if (ok) begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (q_meta[2*i][7:0] !== 8'(16 + i) || dw(q_data[2*i], 0) !== 32'h3000 + 32'(256 * i)
                    || q_sof[2*i] !== 1'b1) begin
                    fails++;
                    $display("FAIL order[%0d]: tag=%h dw0=%h required=%h %h", i, q_meta[2*i][7:0],
                             dw(q_data[2*i], 0), 8'(16 + i), 32'h3000 + 32'(256 * i));
                end
            end
        end
        tick();
    endtask

    task automatic test_zero_len();
        bit ok;
        logic [31:0] c0;
        rcb = 1'b0;
        bus.RC_MFB_DST_RDY = 1'b1;
        clear_q();
        c0 = cnt_req;
        push_req(64'h4000, 11'd0, 8'h03);
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL zero_err_pulse: got=%b required=1", err);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL zero_err_width: got=%b required=0", err);
        end
        tick();
        push_req(64'h4100, 11'd4, 8'h21);
        wait_beats(1, ok);
        repeat (10) tick();
        checks++;
        if (q_data.size() !== 1) begin
            fails++;
            $display("FAIL zero_beats: got=%0d required=1", q_data.size());
        end
        if (ok) begin
            checks++;
            if (q_meta[0] !== {7'h00, 13'd16, 11'd4, 8'h21} || q_pos[0] !== 3'd3 ||
                dw(q_data[0], 3) !== 32'h410C || dw(q_data[0], 4) !== 32'h0) begin
                fails++;
                $display("FAIL zero_follow: meta=%h pos=%0d dw3=%h dw4=%h required=%h 3 410c 0",
                         q_meta[0], q_pos[0], dw(q_data[0], 3), dw(q_data[0], 4),
                         {7'h00, 13'd16, 11'd4, 8'h21});
            end
        end
`ifdef PTC_RC_COMPLETER_CNT_EN
        checks++;
        if (cnt_req !== c0 + 32'd1) begin
            fails++;
            $display("FAIL cnt_req: got=%0d required=%0d", cnt_req, c0 + 32'd1);
        end
`else
        checks++;
        if (cnt_req !== 32'd0 || cnt_cpl !== 32'd0 || c0 !== 32'd0) begin
            fails++;
            $display("FAIL cnt_tied: got=%0d/%0d required=0/0", cnt_req, cnt_cpl);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        rcb = 1'b1;
        bus.RC_MFB_DST_RDY = 1'b0;
        clear_q();
        push_req(64'h5000, 11'd32, 8'h33);
        tick();
        bus.RC_MFB_DST_RDY = 1'b1;
        tick();
        bus.RC_MFB_DST_RDY = 1'b0;
        @(negedge clk);
        checks++;
        if (q_data.size() !== 1 || bus.RC_MFB_SRC_RDY !== 1'b1 || bus.RC_MFB_SOF !== 1'b0) begin
            fails++;
            $display("FAIL mid_setup: beats=%0d src=%b sof=%b required=1 1 0",
                     q_data.size(), bus.RC_MFB_SRC_RDY, bus.RC_MFB_SOF);
        end
        tick();
        rst = 1'b1;
        bus.RC_MFB_DST_RDY = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.RC_MFB_SRC_RDY !== 1'b0 || bus.RQ_DST_RDY !== 1'b0 || bus.RC_MFB_META !== '0) begin
            fails++;
            $display("FAIL mid_reset: src=%b rq_rdy=%b meta=%h required=0 0 0",
                     bus.RC_MFB_SRC_RDY, bus.RQ_DST_RDY, bus.RC_MFB_META);
        end
        tick();
        clear_q();
        push_req(64'h6040, 11'd4, 8'h44);
        wait_beats(1, ok);
        repeat (12) tick();
        if (ok) begin
            checks++;
            if (q_cyc[0] !== acc_cyc + 2) begin
                fails++;
                $display("FAIL post_reset_latency: cycle=%0d required=%0d", q_cyc[0], acc_cyc + 2);
            end
            checks++;
            if (q_meta[0] !== {7'h40, 13'd16, 11'd4, 8'h44} || {q_sof[0], q_eof[0], q_pos[0]} !== 5'b11011
                || dw(q_data[0], 0) !== 32'h6040 || dw(q_data[0], 3) !== 32'h604C) begin
                fails++;
                $display("FAIL post_reset_cpl: meta=%h fr=%b dw0=%h dw3=%h required=%h 11011 6040 604c",
                         q_meta[0], {q_sof[0], q_eof[0], q_pos[0]}, dw(q_data[0], 0),
                         dw(q_data[0], 3), {7'h40, 13'd16, 11'd4, 8'h44});
            end
        end
        checks++;
        if (q_data.size() !== 1) begin
            fails++;
            $display("FAIL abandoned_packet: beats=%0d required=1", q_data.size());
        end
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        fails = 0;
        acc_cyc = 0;
        rst = 1'b1;
        rcb = 1'b0;
        bus.RQ_ADDR = '0;
        bus.RQ_LEN = '0;
        bus.RQ_TAG = '0;
        bus.RQ_SRC_RDY = 1'b0;
        bus.RC_MFB_DST_RDY = 1'b1;
        test_reset();
        test_single();
        test_rcb_split();
        test_rcb128();
        test_back_to_back();
        test_zero_len();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t required=finish earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
